marquee_scroller: RTL



---
 rtl/marquee_scroller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/marquee_scroller.sv
// marquee_scroller
//   Animation stage for an 8-digit common-anode 7-segment display. A fixed message
//   ROM is scrolled through an N_DIG-character window at a programmable step rate.
//   Each new frame is presented together with a one-cycle strobe for the
//   downstream anode-scan driver.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   enable     1 = scrolling runs; 0 = prescaler, divider, pos and frame hold
//   dir        0 = text moves left (pos+1), 1 = text moves right (pos-1)
//   speed_sel  step rate = STEP_HZ / 2**speed_sel (applied at the next divider wrap)
//   restart    synchronous pulse: pos to 0, counters cleared, frame reloaded
//   frame      frame[7k+6:7k] = active-low abcdefg pattern for digit k (k=0 is AN0)
//   frame_stb  high for the one cycle in which a new frame first appears
//   pos        message index shown on the leftmost digit (AN7)
//
// Build option
//   SCROLL_BLINK_EN: after a step that wraps pos to 0 (moving left), the next two
//   steps show blank frames with pos held at 0; scrolling resumes on the third.

module marquee_scroller #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = 4,
    parameter int MSG_LEN = 16,
    parameter int N_DIG   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               dir,
    input  logic [1:0]         speed_sel,
    input  logic               restart,
    output logic [7*N_DIG-1:0] frame,
    output logic               frame_stb,
    output logic [4:0]         pos
);

    localparam int PRESC_MAX = CLK_HZ / STEP_HZ - 1;
    localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC_MAX);
    localparam logic [4:0]    LAST_POS  = 5'(MSG_LEN - 1);

    // Message ROM: "HOLA-FPGA" padded with blanks up to MSG_LEN.
    function automatic logic [7:0] msg_char(input logic [5:0] idx);
        logic [7:0] c;
        case (idx)
            6'd0:    c = "H";
            6'd1:    c = "O";
            6'd2:    c = "L";
            6'd3:    c = "A";
            6'd4:    c = "-";
            6'd5:    c = "F";
            6'd6:    c = "P";
            6'd7:    c = "G";
            6'd8:    c = "A";
            default: c = " ";
        endcase
        return c;
    endfunction

    // Character code to active-low abcdefg; anything unknown is blank.
    function automatic logic [6:0] seg_decode(input logic [7:0] c);
        logic [6:0] s;
        case (c)
            "0":     s = 7'b0000001;
            "1":     s = 7'b1001111;
            "2":     s = 7'b0010010;
            "3":     s = 7'b0000110;
            "4":     s = 7'b1001100;
            "5":     s = 7'b0100100;
            "6":     s = 7'b0100000;
            "7":     s = 7'b0001111;
            "8":     s = 7'b0000000;
            "9":     s = 7'b0000100;
            "A":     s = 7'b0001000;
            "C":     s = 7'b0110001;
            "E":     s = 7'b0110000;
            "F":     s = 7'b0111000;
            "G":     s = 7'b0100001;
            "H":     s = 7'b1001000;
            "L":     s = 7'b1110001;
            "O":     s = 7'b0000001;
            "P":     s = 7'b0011000;
            "U":     s = 7'b1000001;
            "-":     s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q;
    logic [2:0]    div_q;
    logic [2:0]    lim_q;     // divider terminal count latched at each wrap
    logic          init_q;
    logic [4:0]    pos_q;

    logic          base_tick;
    logic          step;
    logic          load;
    logic [2:0]    sel_lim;
    logic [4:0]    pos_step;
    logic [4:0]    pos_next;
    logic [7*N_DIG-1:0] win_next;
    logic [5:0]    idx;

    assign pos       = pos_q;
    assign base_tick = enable && (presc_q == PRESC_TOP);
    assign step      = base_tick && (div_q == lim_q);
    assign load      = init_q || restart;
    assign sel_lim   = 3'((4'd1 << speed_sel) - 4'd1);

    always_comb begin
        pos_step = pos_q;
        if (dir) begin
            pos_step = (pos_q == 5'd0) ? LAST_POS : pos_q - 5'd1;
        end else begin
            pos_step = (pos_q == LAST_POS) ? 5'd0 : pos_q + 5'd1;
        end
    end

    assign pos_next = load ? 5'd0 : pos_step;

    // Window for the position that becomes visible on this edge, so pos and
    // frame always change together.
    always_comb begin
        win_next = '1;
        idx      = '0;
        for (int k = 0; k < N_DIG; k++) begin
            idx = 6'(pos_next) + 6'(N_DIG - 1 - k);
            if (idx >= 6'(MSG_LEN)) begin
                idx = idx - 6'(MSG_LEN);
            end
            win_next[7*k +: 7] = seg_decode(msg_char(idx));
        end
    end

`ifdef SCROLL_BLINK_EN
    logic [1:0] blink_q;   // remaining blank steps after a wrap to 0
    logic       wrap;

    assign wrap = !dir && (pos_q == LAST_POS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 2'd0;
        end else if (load) begin
            blink_q <= 2'd0;
        end else if (step) begin
            if (blink_q != 2'd0) begin
                blink_q <= blink_q - 2'd1;
            end else if (wrap) begin
                blink_q <= 2'd2;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            div_q     <= 3'd0;
            lim_q     <= 3'd0;
            init_q    <= 1'b1;
            pos_q     <= 5'd0;
            frame     <= '1;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            if (load) begin
                presc_q   <= '0;
                div_q     <= 3'd0;
                lim_q     <= sel_lim;
                init_q    <= 1'b0;
                pos_q     <= 5'd0;
                frame     <= win_next;
                frame_stb <= 1'b1;
            end else if (enable) begin
                presc_q <= base_tick ? '0 : presc_q + PW'(1);
                if (base_tick) begin
                    if (div_q == lim_q) begin
                        div_q <= 3'd0;
                        lim_q <= sel_lim;
                    end else begin
                        div_q <= div_q + 3'd1;
                    end
                end
                if (step) begin
                    frame_stb <= 1'b1;
`ifdef SCROLL_BLINK_EN
                    if (blink_q != 2'd0) begin
                        frame <= '1;
                    end else begin
                        pos_q <= pos_next;
                        frame <= win_next;
                    end
`else
                    pos_q <= pos_next;
                    frame <= win_next;
`endif
                end
            end
        end
    end

endmodule
